polar_sc_scheduler: RTL and testbench
=====================================

# polar_sc_scheduler

Successive-cancellation operation scheduler for the polar decoder. On each codeword it walks bit indices 0..N-1 and issues the exact sequence of LLR f/g node operations, leaf-decision requests and partial-sum combine operations that the LLR and partial-sum datapaths must execute. It sits between the top-level decoder controller, which starts it after input and waits for its `done`, and the LLR/partial-sum memories and processing elements, which it drives through valid/ready handshakes.

## Interface
- `LOG2N`, 10, log2 of code length N; legal 2..12.
- `STAGE_W`, 4, width of stage index; must satisfy 2^STAGE_W ≥ LOG2N.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a codeword; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `op_valid` out 1: LLR operation offered.
- `op_ready` in 1: LLR datapath accepts the operation.
- `op_stage` out STAGE_W: stage of the operation; LOG2N-1 = root (channel LLRs), 0 = leaf.
- `op_is_g` out 1: 0 = f, 1 = g.
- `bit_idx` out LOG2N: current bit index i.
- `leaf_req` out 1: leaf LLR for bit i is ready; the datapath must decide u_i.
- `leaf_ack` in 1: u_i has been decided and stored.
- `ps_valid` out 1: partial-sum combine offered.
- `ps_ready` in 1: partial-sum datapath accepts.
- `ps_stage` out STAGE_W: stage of the combine.
- `done` out 1: one-cycle pulse after bit N-1 completes.
- `stall_cnt` out 32: stall cycle count (see Configuration).

## Operation
- States: IDLE, LLR_ISSUE, LEAF, PS_ISSUE, NEXT, DONE.
- IDLE: all outputs 0. On `start`=1: `bit_idx`=0, go to LLR_ISSUE. A `start` pulse outside IDLE is ignored.
- LLR_ISSUE: let s = ctz(i), with s = LOG2N-1 when i = 0.
  - The first operation is at stage s: g if i ≠ 0, f if i = 0.
  - Further f operations follow at stages s-1 down to 0.
  - Each operation is held on `op_*` until `op_valid && op_ready`.
  - After stage 0 is accepted, go to LEAF.
- LEAF: `leaf_req`=1 until `leaf_ack`.
  - On ack with i = N-1: go to DONE.
  - On ack with i odd: go to PS_ISSUE.
  - Otherwise: go to NEXT.
  - `leaf_ack` outside LEAF is ignored.
- PS_ISSUE: let t = cto(i), the count of trailing ones. Combines are issued at stages 0, 1, …, t-1, one per handshake. After the last accepted combine, go to NEXT.
- NEXT: `bit_idx` ← i+1, go to LLR_ISSUE.
- DONE: `done`=1 for one cycle, go to IDLE. `bit_idx` holds N-1 until the next start.
- Totals per codeword: 2N-2 LLR operations, N leaf requests, N-1-LOG2N partial-sum combines.
- Counters are unsigned. `bit_idx` never wraps; the i = N-1 check occurs before NEXT.

## Timing
- Outputs are registered, decoded from state and counters. Reset value of every output is 0.
- `start` sampled in cycle 0 → first `op_valid` in cycle 1.
- With ready held high, one operation is issued per cycle, with no bubble between consecutive ops of one bit.
- LEAF lasts ≥1 cycle. `leaf_ack` in the first LEAF cycle gives exactly 1 cycle.
- NEXT and DONE take 1 cycle each.
- Valid/ready rules:
  - Once valid is asserted, valid, stage, `op_is_g` and `bit_idx` stay stable until accepted.
  - Valid never depends combinationally on ready.
  - `op_valid` and `ps_valid` are never high together.
- `reset` mid-codeword: immediate return to IDLE with all outputs 0. No `done` is produced.

## Configuration
- `SC_SCHED_STALL_CNT_EN` defined:
  - `stall_cnt` counts cycles where `op_valid&&!op_ready`, `ps_valid&&!ps_valid`-style backpressure (`ps_valid&&!ps_ready`) or `leaf_req&&!leaf_ack` holds.
  - It clears on start acceptance and holds its value after DONE.
  - It saturates at 2^32-1.
- Not defined: `stall_cnt` is constant 0 and no counter logic is built.

## Test plan
- LOG2N=3, all readies/acks 1, start at cycle 0:
  - LLR ops (stage, g) in order: (2,f)(1,f)(0,f) | (0,g) | (1,g)(0,f) | (0,g) | (2,g)(1,f)(0,f) | (0,g) | (1,g)(0,f) | (0,g).
  - PS stages: i=1 {0}, i=3 {0,1}, i=5 {0}, i=7 none.
  - `done` at cycle 34.
- LOG2N=3, `op_ready` low 3 cycles on the second op: (1,f) is held stable 3 cycles. `done` at cycle 37. `stall_cnt`=3 with the macro, 0 without.
- LOG2N=3, `leaf_ack` delayed 5 cycles on bit 3: `leaf_req` is held. No `ps_valid` until the ack, then combines at stages 0,1.
- `start` asserted mid-codeword: ignored. The op sequence and `done` timing are unchanged from scenario 1.
- `reset` pulsed during PS_ISSUE of bit 3: all outputs are 0 next cycle and there is no `done`. A new start reproduces scenario 1 exactly.
- LOG2N=10, random ready/ack: 2046 LLR ops, 1024 leaf requests and 1013 combines, then exactly one `done`.

Source files
------------

// File: rtl/polar_sc_scheduler.sv
// polar_sc_scheduler
//
// Successive-cancellation operation scheduler for a polar decoder. For each codeword
// it walks bit indices 0..N-1 (N = 2^LOG2N). For every bit it issues the f/g LLR
// node operations down to the leaf, requests a leaf decision, and then issues the
// partial-sum combines that the decided bit closes off.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   start                  begin a codeword (sampled only while idle)
//   busy                   codeword in progress (through the done cycle)
//   op_valid/op_ready      LLR operation handshake
//   op_stage, op_is_g      LLR operation stage (LOG2N-1 = root) and kind (0 f, 1 g)
//   bit_idx                current bit index
//   leaf_req/leaf_ack      leaf decision handshake for bit bit_idx
//   ps_valid/ps_ready      partial-sum combine handshake
//   ps_stage               partial-sum combine stage
//   done                   one-cycle pulse after the last bit
//   stall_cnt              backpressure cycle count (0 unless enabled)
//
// Build option: define SC_SCHED_STALL_CNT_EN to build the saturating stall counter.
// Without it stall_cnt is tied to 0.

module polar_sc_scheduler #(
   parameter int unsigned LOG2N   = 10,
   parameter int unsigned STAGE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               op_valid,
   input  logic               op_ready,
   output logic [STAGE_W-1:0] op_stage,
   output logic               op_is_g,
   output logic [LOG2N-1:0]   bit_idx,
   output logic               leaf_req,
   input  logic               leaf_ack,
   output logic               ps_valid,
   input  logic               ps_ready,
   output logic [STAGE_W-1:0] ps_stage,
   output logic               done,
   output logic [31:0]        stall_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StLlrIssue,
      StLeaf,
      StPsIssue,
      StNext,
      StDone
   } state_e;

   localparam logic [STAGE_W-1:0] RootStage = STAGE_W'(LOG2N - 1);
   localparam logic [STAGE_W-1:0] StageOne  = STAGE_W'(1);
   localparam logic [LOG2N-1:0]   IdxOne    = LOG2N'(1);

   state_e             state_q;
   logic [STAGE_W-1:0] stage_q;

   // Count of trailing zeros; only ever applied to a nonzero index.
   function automatic logic [STAGE_W-1:0] ctz(input logic [LOG2N-1:0] v);
      logic [STAGE_W-1:0] r;
      logic               found;
      r     = '0;
      found = 1'b0;
      for (int k = 0; k < int'(LOG2N); k++) begin
         if (!found && v[k]) begin
            r     = STAGE_W'(k);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   logic [LOG2N-1:0]   next_idx;
   logic [STAGE_W-1:0] next_stage;
   logic               last_bit;
   logic [STAGE_W:0]   ps_shift;
   logic [LOG2N-1:0]   ps_above;
   logic               ps_last;

   assign next_idx   = bit_idx + IdxOne;
   assign next_stage = ctz(next_idx);
   assign last_bit   = &bit_idx;

   // The combine at stage k is the last one when bit k+1 of the index is 0, i.e. the
   // run of trailing ones ends there. An index in PS_ISSUE is never all ones, so a
   // zero above the current stage always exists.
   assign ps_shift = {1'b0, stage_q} + {{STAGE_W{1'b0}}, 1'b1};
   assign ps_above = bit_idx >> ps_shift;
   assign ps_last  = ~ps_above[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         stage_q  <= '0;
         bit_idx  <= '0;
         busy     <= 1'b0;
         op_valid <= 1'b0;
         op_stage <= '0;
         op_is_g  <= 1'b0;
         leaf_req <= 1'b0;
         ps_valid <= 1'b0;
         ps_stage <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  bit_idx  <= '0;
                  stage_q  <= RootStage;
                  op_stage <= RootStage;
                  op_is_g  <= 1'b0;
                  op_valid <= 1'b1;
                  busy     <= 1'b1;
                  state_q  <= StLlrIssue;
               end
            end
            StLlrIssue: begin
               if (op_ready) begin
                  if (stage_q == '0) begin
                     op_valid <= 1'b0;
                     op_is_g  <= 1'b0;
                     leaf_req <= 1'b1;
                     state_q  <= StLeaf;
                  end else begin
                     // Below the first operation every node is an f.
                     stage_q  <= stage_q - StageOne;
                     op_stage <= stage_q - StageOne;
                     op_is_g  <= 1'b0;
                  end
               end
            end
            StLeaf: begin
               if (leaf_ack) begin
                  leaf_req <= 1'b0;
                  if (last_bit) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else if (bit_idx[0]) begin
                     stage_q  <= '0;
                     ps_stage <= '0;
                     ps_valid <= 1'b1;
                     state_q  <= StPsIssue;
                  end else begin
                     state_q <= StNext;
                  end
               end
            end
            StPsIssue: begin
               if (ps_ready) begin
                  if (ps_last) begin
                     ps_valid <= 1'b0;
                     ps_stage <= '0;
                     state_q  <= StNext;
                  end else begin
                     stage_q  <= stage_q + StageOne;
                     ps_stage <= stage_q + StageOne;
                  end
               end
            end
            StNext: begin
               // The new index is nonzero, so its first operation is a g.
               bit_idx  <= next_idx;
               stage_q  <= next_stage;
               op_stage <= next_stage;
               op_is_g  <= 1'b1;
               op_valid <= 1'b1;
               state_q  <= StLlrIssue;
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef SC_SCHED_STALL_CNT_EN
   logic [31:0] stall_q;
   logic        stall_now;

   assign stall_now = (op_valid && !op_ready) || (ps_valid && !ps_ready) ||
                      (leaf_req && !leaf_ack);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (state_q == StIdle && start) begin
         stall_q <= '0;
      end else if (stall_now && stall_q != 32'hFFFF_FFFF) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_polar_sc_scheduler.sv
// Directed bench for polar_sc_scheduler: an N=8 instance for the cycle-exact
// scenarios and an N=1024 instance for a randomized-handshake totals run.

module tb_polar_sc_scheduler;

`ifdef SC_SCHED_STALL_CNT_EN
   localparam bit StallEn = 1'b1;
`else
   localparam bit StallEn = 1'b0;
`endif

   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // N = 8 instance
   logic        reset3, start3, op_ready3, leaf_ack3, ps_ready3;
   logic        busy3, op_valid3, op_is_g3, leaf_req3, ps_valid3, done3;
   logic [3:0]  op_stage3, ps_stage3;
   logic [2:0]  bit_idx3;
   logic [31:0] stall_cnt3;
   logic [16:0] out3_vec;

   assign out3_vec = {busy3, op_valid3, op_stage3, op_is_g3, bit_idx3, leaf_req3, ps_valid3,
                      ps_stage3, done3};

   polar_sc_scheduler #(.LOG2N(3), .STAGE_W(4)) dut3 (
      .clk(clk), .reset(reset3), .start(start3), .busy(busy3),
      .op_valid(op_valid3), .op_ready(op_ready3), .op_stage(op_stage3), .op_is_g(op_is_g3),
      .bit_idx(bit_idx3), .leaf_req(leaf_req3), .leaf_ack(leaf_ack3),
      .ps_valid(ps_valid3), .ps_ready(ps_ready3), .ps_stage(ps_stage3),
      .done(done3), .stall_cnt(stall_cnt3)
   );

   // N = 1024 instance
   logic        reset10, start10, op_ready10, leaf_ack10, ps_ready10;
   logic        busy10, op_valid10, op_is_g10, leaf_req10, ps_valid10, done10;
   logic [3:0]  op_stage10, ps_stage10;
   logic [9:0]  bit_idx10;
   logic [31:0] stall_cnt10;

   polar_sc_scheduler #(.LOG2N(10), .STAGE_W(4)) dut10 (
      .clk(clk), .reset(reset10), .start(start10), .busy(busy10),
      .op_valid(op_valid10), .op_ready(op_ready10), .op_stage(op_stage10), .op_is_g(op_is_g10),
      .bit_idx(bit_idx10), .leaf_req(leaf_req10), .leaf_ack(leaf_ack10),
      .ps_valid(ps_valid10), .ps_ready(ps_ready10), .ps_stage(ps_stage10),
      .done(done10), .stall_cnt(stall_cnt10)
   );

   // Hand-derived N = 8 schedule
   int exp_op_stage [14] = '{2, 1, 0, 0, 1, 0, 0, 2, 1, 0, 0, 1, 0, 0};
   int exp_op_g     [14] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1};
   int exp_op_bit   [14] = '{0, 0, 0, 1, 2, 2, 3, 4, 4, 4, 5, 6, 6, 7};
   int exp_ps_bit   [4]  = '{1, 3, 3, 5};
   int exp_ps_stage [4]  = '{0, 0, 1, 0};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One N = 8 codeword, starting in the current cycle (cycle 0).
   task automatic run3(input string tag, input int stall_op, input int stall_len,
                       input int delay_bit, input int delay_len, input int mid_start,
                       input int exp_done, input logic [31:0] exp_stall);
      int         cyc, n_op, n_ps, n_leafreq, n_done, done_cyc, stall_left, leaf_left, viol;
      bit         prev_stalled, fin;
      logic [3:0] prev_stage;
      logic       prev_g;
      logic [2:0] prev_bit;
      cyc = 0; n_op = 0; n_ps = 0; n_leafreq = 0; n_done = 0; done_cyc = -1; viol = 0;
      stall_left = stall_len; leaf_left = delay_len; prev_stalled = 1'b0; fin = 1'b0;
      prev_stage = '0; prev_g = 1'b0; prev_bit = '0;
      start3 = 1'b1; op_ready3 = 1'b1; ps_ready3 = 1'b1; leaf_ack3 = 1'b0;
      while (!fin) begin
         step();
         cyc++;
         start3    = (cyc == mid_start);
         op_ready3 = 1'b1;
         if (op_valid3 && n_op == stall_op && stall_left > 0) begin
            op_ready3 = 1'b0;
            stall_left--;
         end
         leaf_ack3 = 1'b1;
         if (leaf_req3 && int'(bit_idx3) == delay_bit && leaf_left > 0) begin
            leaf_ack3 = 1'b0;
            leaf_left--;
         end
         if (cyc == 1) check_eq({tag, " busy@1"}, 32'(busy3), 32'd1);
         if (prev_stalled) begin
            check_eq({tag, " hold valid"}, 32'(op_valid3), 32'd1);
            check_eq({tag, " hold stage"}, 32'(op_stage3), 32'(prev_stage));
            check_eq({tag, " hold is_g"}, 32'(op_is_g3), 32'(prev_g));
            check_eq({tag, " hold bit"}, 32'(bit_idx3), 32'(prev_bit));
         end
         prev_stalled = op_valid3 && !op_ready3;
         prev_stage   = op_stage3;
         prev_g       = op_is_g3;
         prev_bit     = bit_idx3;
         if (op_valid3 && op_ready3) begin
            if (n_op < 14) begin
               check_eq($sformatf("%s op%0d stage", tag, n_op), 32'(op_stage3),
                        exp_op_stage[n_op]);
               check_eq($sformatf("%s op%0d is_g", tag, n_op), 32'(op_is_g3), exp_op_g[n_op]);
               check_eq($sformatf("%s op%0d bit", tag, n_op), 32'(bit_idx3), exp_op_bit[n_op]);
            end
            n_op++;
         end
         if (ps_valid3 && ps_ready3) begin
            if (n_ps < 4) begin
               check_eq($sformatf("%s ps%0d bit", tag, n_ps), 32'(bit_idx3), exp_ps_bit[n_ps]);
               check_eq($sformatf("%s ps%0d stage", tag, n_ps), 32'(ps_stage3),
                        exp_ps_stage[n_ps]);
            end
            n_ps++;
         end
         if (leaf_req3) n_leafreq++;
         if ((op_valid3 && ps_valid3) || (leaf_req3 && (op_valid3 || ps_valid3))) viol++;
         if (done3) begin
            n_done++;
            done_cyc = cyc;
            check_eq({tag, " busy@done"}, 32'(busy3), 32'd1);
            fin = 1'b1;
         end
         if (cyc >= 200) begin
            check_eq({tag, " timeout"}, cyc, exp_done);
            fin = 1'b1;
         end
      end
      start3 = 1'b0;
      step();
      check_eq({tag, " done cycle"}, done_cyc, exp_done);
      check_eq({tag, " op count"}, n_op, 32'd14);
      check_eq({tag, " ps count"}, n_ps, 32'd4);
      check_eq({tag, " leaf_req cycles"}, n_leafreq, 8 + delay_len);
      check_eq({tag, " done count"}, n_done, 32'd1);
      check_eq({tag, " exclusive valids"}, viol, 32'd0);
      check_eq({tag, " busy after"}, 32'(busy3), 32'd0);
      check_eq({tag, " done after"}, 32'(done3), 32'd0);
      check_eq({tag, " idle is_g"}, 32'(op_is_g3), 32'd0);
      check_eq({tag, " bit_idx held"}, 32'(bit_idx3), 32'd7);
      check_eq({tag, " stall_cnt"}, stall_cnt3, exp_stall);
   endtask

   initial begin
      int guard, n_done, n_op, n_leaf, n_ps, n_stall, viol;
      bit fin;
      reset3 = 1'b1; start3 = 1'b0; op_ready3 = 1'b1; leaf_ack3 = 1'b1; ps_ready3 = 1'b1;
      reset10 = 1'b1; start10 = 1'b0; op_ready10 = 1'b0; leaf_ack10 = 1'b0; ps_ready10 = 1'b0;
      step();
      step();
      check_eq("reset outputs n8", 32'(out3_vec), 32'd0);
      check_eq("reset stall_cnt n8", stall_cnt3, 32'd0);
      check_eq("reset outputs n1024",
               32'({busy10, op_valid10, leaf_req10, ps_valid10, done10, bit_idx10}), 32'd0);
      reset3 = 1'b0;
      reset10 = 1'b0;
      step();

      run3("basic", -1, 0, -1, 0, -1, 34, 32'd0);
      run3("op stall", 1, 3, -1, 0, -1, 37, StallEn ? 32'd3 : 32'd0);
      run3("leaf delay", -1, 0, 3, 5, -1, 39, StallEn ? 32'd5 : 32'd0);
      run3("mid start", -1, 0, -1, 0, 12, 34, 32'd0);

      // Reset in the partial-sum phase of bit 3
      op_ready3 = 1'b1; leaf_ack3 = 1'b1; ps_ready3 = 1'b1;
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      guard = 0;
      while (!(ps_valid3 && bit_idx3 == 3'd3) && guard < 100) begin
         step();
         guard++;
      end
      check_eq("rst reached ps bit3", 32'(ps_valid3), 32'd1);
      reset3 = 1'b1;
      step();
      check_eq("rst outputs", 32'(out3_vec), 32'd0);
      check_eq("rst stall_cnt", stall_cnt3, 32'd0);
      reset3 = 1'b0;
      n_done = 0;
      repeat (10) begin
         step();
         if (done3) n_done++;
      end
      check_eq("rst no done", n_done, 32'd0);
      check_eq("rst idle outputs", 32'(out3_vec), 32'd0);
      run3("after reset", -1, 0, -1, 0, -1, 34, 32'd0);

      // N = 1024 with random backpressure
      n_op = 0; n_leaf = 0; n_ps = 0; n_done = 0; n_stall = 0; viol = 0; guard = 0;
      fin = 1'b0;
      start10 = 1'b1;
      while (!fin) begin
         step();
         guard++;
         start10    = 1'b0;
         op_ready10 = ($urandom_range(0, 3) != 0);
         ps_ready10 = ($urandom_range(0, 3) != 0);
         leaf_ack10 = ($urandom_range(0, 1) != 0);
         if (op_valid10 && op_ready10) n_op++;
         if (leaf_req10 && leaf_ack10) n_leaf++;
         if (ps_valid10 && ps_ready10) n_ps++;
         if ((op_valid10 && !op_ready10) || (ps_valid10 && !ps_ready10) ||
             (leaf_req10 && !leaf_ack10)) n_stall++;
         if ((op_valid10 && ps_valid10) || (leaf_req10 && (op_valid10 || ps_valid10))) viol++;
         if (done10) begin
            n_done++;
            fin = 1'b1;
         end
         if (guard >= 40000) begin
            check_eq("n1024 timeout", 32'(done10), 32'd1);
            fin = 1'b1;
         end
      end
      repeat (5) begin
         step();
         if (done10) n_done++;
      end
      check_eq("n1024 llr ops", n_op, 32'd2046);
      check_eq("n1024 leaf reqs", n_leaf, 32'd1024);
      check_eq("n1024 combines", n_ps, 32'd1013);
      check_eq("n1024 done count", n_done, 32'd1);
      check_eq("n1024 exclusive valids", viol, 32'd0);
      check_eq("n1024 bit_idx held", 32'(bit_idx10), 32'd1023);
      check_eq("n1024 stall_cnt", stall_cnt10, StallEn ? n_stall : 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
